// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: datapath sizing, opcode
// encodings, multiply FSM state constants and the shift-add step helper.
package exec_pkg;

  localparam int WIDTH = 8;
  localparam int NREGS = 8;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_OUT = 3'd7;

  // Multiply FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // One shift-add iteration: add the (already shifted) multiplicand when
  // the current multiplier bit is set. Only the low WIDTH bits are kept,
  // which is all the result ever needs.
  function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] mcand,
                                                input logic             mbit);
    return mbit ? acc + mcand : acc;
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// Register file for the execute stage.
// Ports:
//   clk, rst               - clock, synchronous active-low reset
//   rd_addr_a / rd_data_a  - asynchronous read port A
//   rd_addr_b / rd_data_b  - asynchronous read port B
//   wr_en, wr_addr, wr_data - synchronous write port
// R0 always reads as zero and ignores writes.
module exec_regfile
  import exec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 3'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == 3'd0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 3'd0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops, 8-cycle shift-add multiply,
// status flags and a registered output port.
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   op_valid, opcode, src_a, src_b, dest, imm - decoded operation
//   busy            - multiply in flight, new ops are dropped
//   out, out_valid  - OUT result register and its one-cycle strobe
//   zero, carry     - ALU flags
//   overrun         - sticky: an op arrived while busy
module exec_unit
  import exec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       opcode,
  input  logic [2:0]       src_a,
  input  logic [2:0]       src_b,
  input  logic [2:0]       dest,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zero,
  output logic             carry,
  output logic             overrun
);

  logic [WIDTH-1:0] rd_a, rd_b;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic [0:0]       state;
  logic [WIDTH-1:0] mul_mcand, mul_mplier, mul_acc, mul_next;
  logic [2:0]       mul_count, mul_dest;
  logic             mul_done;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_op;

  exec_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (src_a),
    .rd_data_a (rd_a),
    .rd_addr_b (src_b),
    .rd_data_b (rd_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  assign busy     = (state == ST_MUL);
  assign accept   = op_valid && !busy;
  assign mul_next = mul_step(mul_acc, mul_mcand, mul_mplier[0]);
  // The eighth iteration lands on the completion edge, so its sum is
  // written straight into the register file rather than into mul_acc.
  assign mul_done = busy && (mul_count == 3'd7);
  assign alu_op   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_XOR);

  // Single-cycle ALU. The 9th bit of the subtraction is the unsigned borrow.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD:  {alu_carry, alu_res} = {1'b0, rd_a} + {1'b0, rd_b};
      OP_SUB:  {alu_carry, alu_res} = {1'b0, rd_a} - {1'b0, rd_b};
      OP_AND:  alu_res = rd_a & rd_b;
      OP_XOR:  alu_res = rd_a ^ rd_b;
      default: ;
    endcase
  end

  // Write-port arbitration. A multiply completion and an accepted op can
  // never coincide because ops are only accepted while not busy.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = dest;
    wr_data = alu_res;
    if (mul_done) begin
      wr_en   = 1'b1;
      wr_addr = mul_dest;
      wr_data = mul_next;
    end else if (accept) begin
      if (opcode == OP_LDI) begin
        wr_en   = 1'b1;
        wr_data = imm;
      end else if (alu_op) begin
        wr_en = 1'b1;
      end
    end
  end

  // Multiply FSM, flags, output register and overrun tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_count  <= '0;
      mul_dest   <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      zero       <= 1'b0;
      carry      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (op_valid && busy) overrun <= 1'b1;

      if (busy) begin
        mul_acc    <= mul_next;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_count  <= mul_count + 3'd1;
        if (mul_done) begin
          state <= ST_IDLE;
          zero  <= (mul_next == '0);
        end
      end else if (accept) begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            zero  <= (alu_res == '0);
            carry <= alu_carry;
          end
          OP_AND, OP_XOR: zero <= (alu_res == '0);
          OP_MUL: begin
            state      <= ST_MUL;
            mul_mcand  <= rd_a;
            mul_mplier <= rd_b;
            mul_acc    <= '0;
            mul_count  <= '0;
            mul_dest   <= dest;
          end
          OP_OUT: begin
            out       <= rd_a;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit.
module tb_exec_unit;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] opcode = 3'd0, src_a = 3'd0, src_b = 3'd0, dest = 3'd0;
  logic [7:0] imm = 8'd0;
  logic       busy, out_valid, zero, carry, overrun;
  logic [7:0] out;

  int checks = 0;
  int failures = 0;

  exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .opcode    (opcode),
    .src_a     (src_a),
    .src_b     (src_b),
    .dest      (dest),
    .imm       (imm),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .zero      (zero),
    .carry     (carry),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one op for a single edge, then sample 1 time unit after it.
  task automatic apply_stimulus(input logic [2:0] op, input logic [2:0] d,
                                input logic [2:0] a, input logic [2:0] b,
                                input logic [7:0] i);
    @(negedge clk);
    opcode = op; dest = d; src_a = a; src_b = b; imm = i;
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // Step through the 8 multiply cycles checking busy; optionally present
  // an op on edge number inject_at (1..8) after acceptance.
  task automatic run_mul(input int inject_at, input logic [2:0] op,
                         input logic [2:0] d, input logic [7:0] i,
                         input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == inject_at) begin
        opcode = op; dest = d; src_a = 3'd1; src_b = 3'd2; imm = i;
        op_valid = 1'b1;
      end
      @(posedge clk);
      #1 op_valid = 1'b0;
      check_output($sformatf("%s_busy_k%0d", tag, k), {7'd0, busy},
                   (k < 8) ? 8'd1 : 8'd0);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", {7'd0, busy}, 8'd0);
    check_output("rst_out", out, 8'd0);
    check_output("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check_output("rst_zero", {7'd0, zero}, 8'd0);
    check_output("rst_carry", {7'd0, carry}, 8'd0);
    check_output("rst_overrun", {7'd0, overrun}, 8'd0);
    @(negedge clk) rst = 1'b1;

    // ADD and OUT with back-to-back dependency
    apply_stimulus(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h25);
    apply_stimulus(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h17);
    apply_stimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    check_output("add_zero", {7'd0, zero}, 8'd0);
    check_output("add_carry", {7'd0, carry}, 8'd0);
    apply_stimulus(OP_OUT, 3'd0, 3'd3, 3'd0, 8'h00);
    check_output("out_r3", out, 8'h3C);
    check_output("out_r3_valid", {7'd0, out_valid}, 8'd1);
    @(posedge clk) #1;
    check_output("out_r3_valid_drop", {7'd0, out_valid}, 8'd0);
    check_output("out_r3_hold", out, 8'h3C);

    // SUB with borrow, XOR to zero keeps carry
    apply_stimulus(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h10);
    apply_stimulus(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h20);
    apply_stimulus(OP_SUB, 3'd4, 3'd1, 3'd2, 8'h00);
    check_output("sub_carry", {7'd0, carry}, 8'd1);
    check_output("sub_zero", {7'd0, zero}, 8'd0);
    apply_stimulus(OP_OUT, 3'd0, 3'd4, 3'd0, 8'h00);
    check_output("out_r4", out, 8'hF0);
    apply_stimulus(OP_XOR, 3'd5, 3'd4, 3'd4, 8'h00);
    check_output("xor_zero", {7'd0, zero}, 8'd1);
    check_output("xor_carry_kept", {7'd0, carry}, 8'd1);

    // ADD wrapping to zero, then AND leaves carry alone
    apply_stimulus(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hFF);
    apply_stimulus(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h01);
    apply_stimulus(OP_SUB, 3'd3, 3'd1, 3'd2, 8'h00);
    check_output("sub_noborrow_carry", {7'd0, carry}, 8'd0);
    apply_stimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    check_output("add_wrap_zero", {7'd0, zero}, 8'd1);
    check_output("add_wrap_carry", {7'd0, carry}, 8'd1);
    apply_stimulus(OP_AND, 3'd3, 3'd1, 3'd2, 8'h00);
    check_output("and_zero", {7'd0, zero}, 8'd0);
    check_output("and_carry_kept", {7'd0, carry}, 8'd1);
    apply_stimulus(OP_OUT, 3'd0, 3'd3, 3'd0, 8'h00);
    check_output("out_and", out, 8'h01);

    // MUL 0x0D * 0x0B = 0x8F, zero set beforehand to see it clear at T+8
    apply_stimulus(OP_XOR, 3'd5, 3'd1, 3'd1, 8'h00);
    apply_stimulus(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h0D);
    apply_stimulus(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h0B);
    apply_stimulus(OP_MUL, 3'd6, 3'd1, 3'd2, 8'h00);
    check_output("mul1_busy_t0", {7'd0, busy}, 8'd1);
    check_output("mul1_zero_pending", {7'd0, zero}, 8'd1);
    run_mul(0, OP_NOP, 3'd0, 8'h00, "mul1");
    check_output("mul1_zero", {7'd0, zero}, 8'd0);
    check_output("mul1_carry_kept", {7'd0, carry}, 8'd1);
    check_output("mul1_no_overrun", {7'd0, overrun}, 8'd0);
    apply_stimulus(OP_OUT, 3'd0, 3'd6, 3'd0, 8'h00);
    check_output("out_mul1", out, 8'h8F);

    // MUL 0x10 * 0x10 -> 0x00; op on completion edge is dropped
    apply_stimulus(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h10);
    apply_stimulus(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h10);
    apply_stimulus(OP_MUL, 3'd6, 3'd1, 3'd2, 8'h00);
    run_mul(8, OP_LDI, 3'd7, 8'h55, "mul2");
    check_output("mul2_zero", {7'd0, zero}, 8'd1);
    check_output("mul2_overrun", {7'd0, overrun}, 8'd1);
    // first edge after completion is accepted
    apply_stimulus(OP_OUT, 3'd0, 3'd6, 3'd0, 8'h00);
    check_output("out_mul2", out, 8'h00);
    check_output("out_mul2_valid", {7'd0, out_valid}, 8'd1);
    apply_stimulus(OP_OUT, 3'd0, 3'd7, 3'd0, 8'h00);
    check_output("r7_after_drop_at_end", out, 8'h00);

    // ADD during MUL is dropped, overrun stays set
    apply_stimulus(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h03);
    apply_stimulus(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h05);
    apply_stimulus(OP_MUL, 3'd5, 3'd1, 3'd2, 8'h00);
    run_mul(3, OP_ADD, 3'd7, 8'h00, "mul3");
    apply_stimulus(OP_OUT, 3'd0, 3'd7, 3'd0, 8'h00);
    check_output("r7_after_drop_mid", out, 8'h00);
    apply_stimulus(OP_OUT, 3'd0, 3'd5, 3'd0, 8'h00);
    check_output("out_mul3", out, 8'h0F);
    check_output("overrun_sticky", {7'd0, overrun}, 8'd1);

    // R0 hardwired to zero
    apply_stimulus(OP_LDI, 3'd0, 3'd0, 3'd0, 8'hFF);
    apply_stimulus(OP_OUT, 3'd0, 3'd0, 3'd0, 8'h00);
    check_output("out_r0", out, 8'h00);

    // Reset mid-MUL aborts it
    apply_stimulus(OP_MUL, 3'd4, 3'd1, 3'd2, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check_output("abort_busy", {7'd0, busy}, 8'd0);
    check_output("abort_out", out, 8'h00);
    check_output("abort_out_valid", {7'd0, out_valid}, 8'd0);
    check_output("abort_zero", {7'd0, zero}, 8'd0);
    check_output("abort_carry", {7'd0, carry}, 8'd0);
    check_output("abort_overrun", {7'd0, overrun}, 8'd0);
    @(negedge clk) rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_output("abort_busy_late", {7'd0, busy}, 8'd0);
    apply_stimulus(OP_OUT, 3'd0, 3'd4, 3'd0, 8'h00);
    check_output("abort_r4", out, 8'h00);
    check_output("abort_r4_valid", {7'd0, out_valid}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
